// File: rtl/ifetch_pkg.sv
// Shared constants for the instruction-fetch slice.
// These take the place of the old const.h defines.
package ifetch_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [1:0]  IMEM_SIZE_WORD   = 2'd2;
    localparam int unsigned PC_STEP          = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/ifetch_fifo.sv
// Generic DEPTH x W synchronous FIFO with flush. The head entry is read straight from storage.
// Storage is cleared on reset, so the head reads zero until the first write.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 96
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [W-1:0]             dout
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            mem   <= '{default: '0};
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the fetch PC, drives the imem read port and
// buffers {pc, instruction} pairs toward decode; a redirect flushes them.
module ifetch
    import ifetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 64,
    parameter int unsigned      ADDR_W   = 10,
    parameter int unsigned      DEPTH    = 2,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [1:0]             imem_word,
    input  logic [XLEN-1:0]        imem_data,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [INST_W-1:0]      out_inst,
    output logic [$clog2(DEPTH):0] fifo_count
);

    logic [XLEN-1:0]        pc;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic [XLEN+INST_W-1:0] din;
    logic [XLEN+INST_W-1:0] head;
    logic                   unused_bits;

    assign unused_bits = ^{imem_data[XLEN-1:INST_W], redirect_pc[1:0]};

    always_comb begin
        imem_addr = pc[ADDR_W-1:0];
        imem_word = IMEM_SIZE_WORD;
        // A full FIFO never accepts a push, even when the head pops this cycle.
        push      = !rst && !redirect_valid && !full;
        pop       = !empty && out_ready && !redirect_valid;
        din       = {pc, imem_data[INST_W-1:0]};
        out_valid = !empty;
        out_pc    = head[XLEN+INST_W-1:INST_W];
        out_inst  = head[INST_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[XLEN-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + XLEN'(PC_STEP);
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (XLEN + INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .count (fifo_count),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ifetch;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [1:0]        imem_word;
    logic [XLEN-1:0]   imem_data;
    logic              redirect_valid = 1'b0;
    logic [XLEN-1:0]   redirect_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_inst;
    logic [1:0]        fifo_count;

    int checks = 0;
    int errors = 0;

    ifetch #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_word      (imem_word),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return 32'h1234_5000 ^ {22'h0, a[9:0]};
    endfunction

    // Upper half is junk so a wrong slice of imem_data is visible.
    assign imem_data = {32'hCAFE_F00D, 32'h1234_5000 ^ {22'h0, imem_addr}};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch PC plus a queue of {pc, inst} entries.
    logic [63:0] m_pc = '0;
    logic [95:0] q[$];
    bit          m_known = 0;
    bit          m_full;
    bit          m_pop;

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1;
            m_pc    = 64'h0;
            q.delete();
        end else if (m_known) begin
            if (redirect_valid) begin
                m_pc = {redirect_pc[63:2], 2'b00};
                q.delete();
            end else begin
                m_full = (q.size() >= DEPTH);
                m_pop  = (q.size() != 0) && out_ready;
                if (m_pop) void'(q.pop_front());
                if (!m_full) begin
                    q.push_back({m_pc, inst_of(m_pc)});
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            check("imem_addr", 64'(imem_addr), 64'(m_pc[9:0]));
            check("imem_word", 64'(imem_word), 64'd2);
            check("fifo_count", 64'(fifo_count), 64'(q.size()));
            check("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_pc", out_pc, q[0][95:32]);
                check("out_inst", 64'(out_inst), 64'(q[0][31:0]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_head(input string name, input logic [63:0] pc, input logic [31:0] inst);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_pc"}, out_pc, pc);
        check({name, "_inst"}, 64'(out_inst), 64'(inst));
    endtask

    initial begin
        int r;

        // Reset state
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        tick(); tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);

        // 1: streaming with out_ready high
        rst = 1'b0;
        tick(); expect_head("t1_a", 64'd0,  32'h1234_5000);
        tick(); expect_head("t1_b", 64'd4,  32'h1234_5004);
        tick(); expect_head("t1_c", 64'd8,  32'h1234_5008);
        tick(); expect_head("t1_d", 64'd12, 32'h1234_500C);

        // 2: back-pressure saturates at DEPTH, then drains without gap
        rst = 1'b1; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick(); check("t2_cnt1", 64'(fifo_count), 64'd1);
        tick(); check("t2_cnt2", 64'(fifo_count), 64'd2);
        tick(); check("t2_cnt_sat", 64'(fifo_count), 64'd2);
        check("t2_pc_frozen", 64'(imem_addr), 64'd8);
        check("t2_head", out_pc, 64'd0);
        out_ready = 1'b1;
        tick(); expect_head("t2_a", 64'd4, 32'h1234_5004);
        check("t2_cnt_drain", 64'(fifo_count), 64'd1);
        tick(); expect_head("t2_b", 64'd8, 32'h1234_5008);
        tick(); expect_head("t2_c", 64'd12, 32'h1234_500C);

        // 3: redirect with full FIFO
        out_ready = 1'b0;
        tick(); check("t3_full", 64'(fifo_count), 64'd2);
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        tick();
        check("t3_cnt", 64'(fifo_count), 64'd0);
        check("t3_valid", 64'(out_valid), 64'd0);
        check("t3_addr", 64'(imem_addr), 64'h100);
        redirect_valid = 1'b0;
        tick(); expect_head("t3_a", 64'h100, 32'h1234_5100);
        out_ready = 1'b1;
        tick(); expect_head("t3_b", 64'h104, 32'h1234_5104);

        // 4: misaligned target, redirect squashes concurrent pop
        redirect_valid = 1'b1; redirect_pc = 64'h103;
        tick(); check("t4_cnt", 64'(fifo_count), 64'd0);
        redirect_valid = 1'b0;
        tick(); expect_head("t4_a", 64'h100, 32'h1234_5100);

        // 5: PC wrap
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick(); check("t5_addr_hi", 64'(imem_addr), 64'h3FC);
        redirect_valid = 1'b0;
        tick(); expect_head("t5_a", 64'hFFFF_FFFF_FFFF_FFFC, 32'h1234_53FC);
        check("t5_addr_lo", 64'(imem_addr), 64'h0);
        tick(); expect_head("t5_b", 64'h0, 32'h1234_5000);

        // 6: reset beats redirect with FIFO full
        out_ready = 1'b0;
        tick(); tick(); check("t6_full", 64'(fifo_count), 64'd2);
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h200;
        tick();
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_cnt", 64'(fifo_count), 64'd0);
        check("t6_addr", 64'(imem_addr), 64'd0);
        check("t6_out_pc", out_pc, 64'd0);
        rst = 1'b0; redirect_valid = 1'b0;
        tick(); expect_head("t6_a", 64'd0, 32'h1234_5000);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            rst            = (r == 0);
            redirect_valid = (r >= 1 && r <= 6);
            case ($urandom_range(0, 3))
                0:       redirect_pc = {$urandom, $urandom};
                1:       redirect_pc = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
                default: redirect_pc = 64'($urandom_range(0, 4095));
            endcase
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction-fetch stage sitting between the pc register/imem pair and the decode/execute path inside soc.
- Owns the fetch PC and drives the imem read port.
- Buffers fetched {pc, instruction} pairs in a small FIFO toward decode, using a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes in-flight instructions.

Parameters:
- XLEN, 64, width of PC and imem data bus.
- ADDR_W, 10, width of imem address.
- DEPTH, 2, fetch FIFO entries; power of 2, minimum 2.
- RESET_PC, 64'h0, fetch PC loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_W  imem byte address, equal to pc[ADDR_W-1:0].
- imem_word  output  2  imem access size; constant 2'd2 (32-bit word).
- imem_data  input  XLEN  imem read data; combinational, valid in the same cycle as imem_addr; instruction is imem_data[31:0].
- redirect_valid  input  1  load a new fetch PC and flush the FIFO.
- redirect_pc  input  XLEN  redirect target.
- out_valid  output  1  FIFO head holds a valid instruction.
- out_ready  input  1  consumer accepts the head this cycle.
- out_pc  output  XLEN  PC of the head instruction.
- out_inst  output  32  head instruction.
- fifo_count  output  $clog2(DEPTH)+1  occupancy, for debug and verification.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst.
- On reset (rst sampled high):
  - pc <= RESET_PC.
  - FIFO emptied: count=0, read/write pointers=0.
  - Consequences: out_valid=0 and fifo_count=0 the following cycle.
  - out_pc and out_inst read 0 after reset.
  - rst overrides redirect and all handshakes.
  - rst asserted mid-stream discards all buffered entries.
- Fetch:
  - imem_addr = pc[ADDR_W-1:0] combinationally every cycle.
  - push = !rst && !redirect_valid && (count < DEPTH).
  - On push: write {pc, imem_data[31:0]} at wptr; pc <= pc + 4 (mod 2^XLEN; wraps 0xFFFF_FFFF_FFFF_FFFC -> 0).
  - Address above 2^ADDR_W aliases via truncation; no fault is raised.
- Full:
  - No push when count == DEPTH, even if a pop occurs that cycle.
  - pc holds. The same address is re-fetched next cycle; imem reads have no side effects.
- Output:
  - out_valid = (count != 0).
  - out_pc and out_inst come from the head entry, driven straight from storage (registered, no combinational path from imem_data).
  - pop = out_valid && out_ready && !redirect_valid.
  - Push and pop in the same cycle leave count unchanged.
  - out_ready while empty has no effect.
- Redirect (redirect_valid high, rst low):
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; the low two bits are forced to 0.
  - count <= 0 and rptr = wptr <= 0.
  - No push. Any pop that cycle is discarded: the consumer must treat it as squashed.
  - Redirect held high for several cycles reloads pc each cycle; nothing is fetched.
- Latency:
  - The first rst-low cycle fetches RESET_PC; out_valid rises the next cycle.
  - Redirect at cycle N: fetch at target in N+1; out_valid with out_pc=target in N+2.
- Steady state: with out_ready held high, throughput is one instruction per cycle.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally; count is tracked separately.

Decomposition:
- Shared package (e.g. the existing const.h, as defines):
  - INST_W=32.
  - IMEM_SIZE_WORD=2'd2.
  - PC_STEP=4.
  - RESET_PC default.
- One sub-module: ifetch_fifo, a generic DEPTH x (XLEN+32) synchronous FIFO.
  - Inputs: push, pop, flush.
  - Outputs: count, full, empty, head data.
- ifetch holds the PC/redirect logic and instantiates ifetch_fifo.

Test Plan:
1. Reset with RESET_PC=0, imem returns inst=addr, out_ready=1 -> out_valid rises the cycle after rst falls; out_pc sequence 0,4,8,12 on consecutive cycles with matching out_inst.
2. out_ready=0 after reset -> fifo_count 1 then 2 and saturates at 2; pc frozen at 8; out_pc stays 0. Raising out_ready then drains 0,4 and continues at 8 with no gap or duplicate.
3. Redirect at cycle N with redirect_pc=0x100 while the FIFO holds 2 entries -> fifo_count=0 and out_valid=0 at N+1; out_pc=0x100 at N+2, then 0x104.
4. redirect_pc=0x103 -> next out_pc=0x100. Redirect asserted together with out_ready=1 while valid -> popped entry discarded, count=0.
5. Wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC -> out_pc of that entry followed by 0; imem_addr shows 0x3FC then 0x000.
6. Assert rst for one cycle with FIFO full and redirect_valid=1 -> next cycle out_valid=0, fifo_count=0, pc=RESET_PC (the redirect is ignored).
